// File: rtl/serial_adder_sequencer.sv
// Bit-serial adder controller: one dual-rail full adder is time-shared over a
// WIDTH-bit word, LSB first, with registered sum/carry/zero and a done pulse.

module AdderBlock (
  input  logic b_bit,
  input  logic c_bit,
  input  logic carry_in,
  input  logic carry_in_n,
  output logic sum_bit,
  output logic carry_out,
  output logic carry_out_n
);
  assign sum_bit     = b_bit ^ c_bit ^ carry_in;
  assign carry_out   = (b_bit & c_bit) | (carry_in & (b_bit ^ c_bit));
  // The negative rail is built from complemented inputs so that a rail fault
  // shows up as carry_out == carry_out_n.
  assign carry_out_n = (~b_bit & ~c_bit) | (~b_bit & carry_in_n) | (~c_bit & carry_in_n);
endmodule

module serial_adder_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic             carry_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             zero,
  output logic             fault
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] b_sh_q, c_sh_q, sum_sh_q, sum_out_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             carry_q, carry_out_q, zero_q, fault_q, busy_q, done_q;

  logic             adder_sum, adder_cout, adder_cout_n;
  logic [WIDTH-1:0] sum_fin_d;

  AdderBlock u_adder (
    .b_bit      (b_sh_q[0]),
    .c_bit      (c_sh_q[0]),
    .carry_in   (carry_q),
    .carry_in_n (~carry_q),
    .sum_bit    (adder_sum),
    .carry_out  (adder_cout),
    .carry_out_n(adder_cout_n)
  );

  // Sum word as it will look once the current bit has been shifted in.
  assign sum_fin_d = {adder_sum, sum_sh_q[WIDTH-1:1]};

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      b_sh_q      <= '0;
      c_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_out_q   <= '0;
      bit_cnt_q   <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            b_sh_q    <= b_in;
            c_sh_q    <= c_in;
            sum_sh_q  <= '0;
            carry_q   <= carry_init;
            bit_cnt_q <= '0;
            fault_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ADD;
          end else begin
            state_q <= IDLE;
          end
        end
        ADD: begin
          b_sh_q    <= b_sh_q >> 1;
          c_sh_q    <= c_sh_q >> 1;
          sum_sh_q  <= sum_fin_d;
          carry_q   <= adder_cout;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (adder_cout_n == adder_cout) fault_q <= 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            sum_out_q   <= sum_fin_d;
            carry_out_q <= adder_cout;
            zero_q      <= (sum_fin_d == '0);
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_out   = sum_out_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Directed bench for serial_adder_sequencer (WIDTH=8) with hand-computed results.

module tb_serial_adder_sequencer;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] b_in = '0, c_in = '0;
  logic             carry_init = 1'b0;
  logic             busy, done, carry_out, zero, fault;
  logic [WIDTH-1:0] sum_out;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_sequencer #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .b_in      (b_in),
    .c_in      (c_in),
    .carry_init(carry_init),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .zero      (zero),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [WIDTH-1:0] exp_sum,
                                    input logic exp_co, input logic exp_z, input logic exp_f);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".sum"}, sum_out, exp_sum);
    check({tag, ".carry"}, carry_out, exp_co);
    check({tag, ".zero"}, zero, exp_z);
    check({tag, ".fault"}, fault, exp_f);
  endtask

  // Start an add, then count edges until done (bounded); checks busy/done exclusivity.
  task automatic run_add(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                         input logic ci, output int lat);
    @(negedge clock);
    b_in = b; c_in = c; carry_init = ci; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("accept.busy", busy, 1);
    lat = 0;
    while (lat < 20) begin
      @(posedge clock); #1;
      lat++;
      if (busy && done) check("busy_and_done", 1, 0);
      if (done) break;
    end
  endtask

  initial begin
    int lat, done_cnt, first_done, second_done;

    // Reset state
    #3;
    check_idle_outputs("reset", 8'h00, 0, 0, 0);
    @(negedge clock); reset = 1'b0;

    // 0x35 + 0x4A
    run_add(8'h35, 8'h4A, 1'b0, lat);
    check("t1.latency", lat, 8);
    check("t1.done", done, 1);
    check("t1.busy", busy, 0);
    check("t1.sum", sum_out, 8'h7F);
    check("t1.carry", carry_out, 0);
    check("t1.zero", zero, 0);
    check("t1.fault", fault, 0);
    @(posedge clock); #1;
    check_idle_outputs("t1.after", 8'h7F, 0, 0, 0);

    // Overflow to zero, via operand and via carry_init
    run_add(8'hFF, 8'h01, 1'b0, lat);
    check("t2a.latency", lat, 8);
    check("t2a.sum", sum_out, 8'h00);
    check("t2a.carry", carry_out, 1);
    check("t2a.zero", zero, 1);
    run_add(8'hFF, 8'h00, 1'b1, lat);
    check("t2b.sum", sum_out, 8'h00);
    check("t2b.carry", carry_out, 1);
    check("t2b.zero", zero, 1);

    // start during ADD ignored, operand changes after acceptance ignored
    @(negedge clock);
    b_in = 8'h10; c_in = 8'h20; carry_init = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    done_cnt = 0; first_done = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      b_in = 8'(i * 37);
      c_in = 8'hC3;
      carry_init = 1'b1;
      start = (i == 3);
      @(posedge clock); #1;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
      end
    end
    start = 1'b0;
    check("t3.done_pulses", done_cnt, 1);
    check("t3.done_edge", first_done, 8);
    check("t3.sum", sum_out, 8'h30);
    check("t3.carry", carry_out, 0);

    // Back-to-back: start held high through DONE
    @(negedge clock);
    b_in = 8'h80; c_in = 8'h80; carry_init = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    b_in = 8'h01; c_in = 8'h02;
    first_done = 0; second_done = 0;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clock); #1;
      if (done && first_done == 0) begin
        first_done = i;
        check("t4a.sum", sum_out, 8'h00);
        check("t4a.carry", carry_out, 1);
        check("t4a.zero", zero, 1);
      end else if (done) begin
        second_done = i;
        check("t4b.sum", sum_out, 8'h03);
        check("t4b.carry", carry_out, 0);
        check("t4b.zero", zero, 0);
      end
    end
    start = 1'b0;
    check("t4.first_edge", first_done, 8);
    check("t4.second_edge", second_done, 17);
    @(posedge clock); #1;
    check("t4.idle_busy", busy, 0);

    // Reset in the middle of an add
    run_add(8'h0F, 8'h01, 1'b0, lat);
    check("t5a.sum", sum_out, 8'h10);
    @(negedge clock);
    b_in = 8'hAA; c_in = 8'h55; carry_init = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("t5.reset", 8'h00, 0, 0, 0);
    done_cnt = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (done) done_cnt++;
    end
    check("t5.no_done", done_cnt, 0);
    @(negedge clock); reset = 1'b0;
    run_add(8'h01, 8'h01, 1'b0, lat);
    check("t5b.latency", lat, 8);
    check("t5b.sum", sum_out, 8'h02);

    // Dual-rail fault on bit 0 of 0x12+0x34 (bit-0 carry is 0, so force rail to 0)
    @(negedge clock);
    b_in = 8'h12; c_in = 8'h34; carry_init = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    force dut.adder_cout_n = 1'b0;
    @(posedge clock); #1;
    release dut.adder_cout_n;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("t6.latency", lat, 8);
    check("t6.fault", fault, 1);
    check("t6.sum", sum_out, 8'h46);
    check("t6.carry", carry_out, 0);
    @(posedge clock); #1;
    check("t6.fault_sticky", fault, 1);
    @(negedge clock);
    b_in = 8'h01; c_in = 8'h01; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("t6.fault_cleared", fault, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_adder_sequencer.md
# serial_adder_sequencer

Bit-serial add controller that time-shares one `AdderBlock` (one-bit full adder with dual-rail carry) across a full ALU word. It latches two operands, drives one bit pair per clock through the adder LSB-first, and holds the carry in a register between bits. At the end it delivers the registered sum, carry and zero flag with a one-cycle done pulse. It sits between the B/C register pair and the ALU result path, in place of a WIDTH-wide ripple chain of adder blocks.

## Interface
- `WIDTH`, 8, operand/sum width in bits (≥2)
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; returns block to IDLE
- `start`  in  1  request an add; sampled only in IDLE or DONE
- `b_in`  in  WIDTH  B operand, sampled on the accepting edge
- `c_in`  in  WIDTH  C operand, sampled on the accepting edge
- `carry_init`  in  1  carry into bit 0
- `busy`  out  1  high while bits are in flight (ADD)
- `done`  out  1  one-cycle pulse: results valid
- `sum_out`  out  WIDTH  registered sum
- `carry_out`  out  1  registered carry out of bit WIDTH-1
- `zero`  out  1  registered: sum_out == 0
- `fault`  out  1  sticky dual-rail carry error

## Operation
- One `AdderBlock` instance, ports in order: b_bit, c_bit, carry_in, carry_in_n, sum_bit, carry_out, carry_out_n.
- Adder drive: b_bit = b_sh[0], c_bit = c_sh[0], carry_in = carry_reg, carry_in_n = ~carry_reg.
- States: IDLE, ADD, DONE.
  - IDLE: start=1 → load b_sh=b_in, c_sh=c_in, carry_reg=carry_init, bit_cnt=0, clear fault, → ADD. Otherwise stay.
  - ADD: each edge: b_sh, c_sh shift right one; sum_bit shifts into sum_sh MSB (sum_sh shifts right); carry_reg ← adder carry_out; bit_cnt++. On edge where bit_cnt == WIDTH-1: sum_out ← final sum_sh, carry_out ← adder carry_out, zero ← (final sum == 0), done ← 1, → DONE.
  - DONE: done=1 for this cycle only. start=1 → same load as IDLE, → ADD (back-to-back). Else → IDLE.
- start in ADD is ignored; no queueing.
- Operands are captured once; b_in/c_in/carry_init changes after acceptance have no effect.
- Arithmetic: {carry_out, sum_out} = b_in + c_in + carry_init, unsigned, WIDTH+1 bits.
- Dual-rail check: during ADD, if adder carry_out_n == carry_out, set fault. fault is sticky until reset or next accepted start; it does not alter sequencing or results.
- sum_out, carry_out, zero hold their values between operations and only update at completion.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, sum_out=0, carry_out=0, zero=0, fault=0, internal shift regs/carry_reg/bit_cnt=0. Reset mid-ADD discards the operation; no done pulse.
- Start accepted at edge k → busy=1 from k to k+WIDTH; bit i processed between edges k+i and k+i+1.
- Results and done registered at edge k+WIDTH; done high exactly one cycle (k+WIDTH to k+WIDTH+1); busy low from edge k+WIDTH.
- Latency start-edge → done = WIDTH cycles; back-to-back throughput = one result per WIDTH+1 cycles (start accepted in DONE at edge k+WIDTH+1).
- busy and done are never high together.

## Test plan
- WIDTH=8, b_in=0x35, c_in=0x4A, carry_init=0, start at edge k → done at k+8, sum_out=0x7F, carry_out=0, zero=0, fault=0.
- b_in=0xFF, c_in=0x01, carry_init=0 → sum_out=0x00, carry_out=1, zero=1; then b_in=0xFF, c_in=0x00, carry_init=1 → sum_out=0x00, carry_out=1, zero=1.
- Accept 0x10+0x20; pulse start at edge k+3 with different operands and change b_in every cycle → ignored; result 0x30, single done pulse at k+8.
- Hold start high through DONE with 0x80+0x80 then 0x01+0x02 → done at k+8 (0x00, carry 1, zero 1) and k+17 (0x03, carry 0, zero 0).
- Complete 0x0F+0x01 (sum 0x10), then start 0xAA+0x55 and assert reset at bit 4 → immediately all outputs 0, IDLE, no done; after release 0x01+0x01 → 0x02 in 8 cycles.
- Force adder carry_out_n equal to carry_out for one bit cycle during 0x12+0x34 → fault=1 at done, sum_out=0x46; next accepted start clears fault to 0.
